// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and bit voting.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_DIVISOR = 651;
  localparam int OVERSAMPLE      = 16;
  localparam int MID_SAMPLE      = 8;
  localparam int DATA_BITS       = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head reads as zero while empty.
module rx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x oversampling UART receiver with majority voting, sticky error flags and a byte FIFO.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DIVISOR    = DEFAULT_DIVISOR,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [7:0]       rd_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overrun,
  output logic             frame_err
);

  localparam int TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  rx_state_t   state;
  rx_state_t   next_state;
  logic        rx_meta;
  logic        rx_s;
  logic [TW-1:0] tick_cnt;
  logic        tick;
  logic [3:0]  sample_idx;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        v7;
  logic        v8;
  logic        vote;
  logic        start_det;
  logic        enter_data;
  logic        push_req;
  logic        frame_set;
  logic        overrun_set;
  logic        fifo_full;
  logic        fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TW'(DIVISOR - 1));
  assign vote = majority3(v7, v8, rx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Start bit is qualified at its middle; framing then runs on the same sample count,
  // so each data bit wraps to sample 0 on its edge and is voted around its centre.
  always_comb begin
    next_state = state;
    start_det  = 1'b0;
    enter_data = 1'b0;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          next_state = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (sample_idx == 4'(MID_SAMPLE) && rx_s) begin
            next_state = IDLE;
          end else if (sample_idx == 4'(OVERSAMPLE - 1)) begin
            next_state = DATA;
            enter_data = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick && sample_idx == 4'(OVERSAMPLE - 1) && bit_idx == 3'(DATA_BITS - 1))
          next_state = STOP;
      end
      STOP: begin
        if (tick && sample_idx == 4'(MID_SAMPLE + 1)) begin
          if (vote) begin
            push_req   = 1'b1;
            next_state = IDLE;
          end else begin
            frame_set  = 1'b1;
            next_state = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      sample_idx <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      v7         <= 1'b0;
      v8         <= 1'b0;
    end else begin
      if (start_det) begin
        tick_cnt   <= '0;
        sample_idx <= '0;
      end else if (tick) begin
        tick_cnt   <= '0;
        sample_idx <= sample_idx + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (enter_data)
        bit_idx <= '0;
      else if (state == DATA && tick && sample_idx == 4'(OVERSAMPLE - 1))
        bit_idx <= bit_idx + 3'd1;

      if (tick && sample_idx == 4'(MID_SAMPLE - 1)) v7 <= rx_s;
      if (tick && sample_idx == 4'(MID_SAMPLE))     v8 <= rx_s;

      if (state == DATA && tick && sample_idx == 4'(MID_SAMPLE + 1))
        shift_reg <= {vote, shift_reg[7:1]};
    end
  end

  // A byte is lost only when the FIFO is full and no pop frees a slot this cycle.
  assign overrun_set = push_req && fifo_full && !(rd_en && !fifo_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (shift_reg),
    .pop       (rd_en),
    .head      (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: serial frames in, queued bytes checked on every pop.
module tb_uart_rx_buffered;

  localparam int DIV     = 4;
  localparam int BIT_CLK = DIV * 16;
  localparam int DEPTH   = 4;
  localparam int CW      = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_in;
  logic          rd_en;
  logic          clr_err;
  logic [7:0]    rd_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic          frame_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_overrun;
  logic       exp_frame;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .DIVISOR    (DIV),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    for (int c = 0; c < BIT_CLK; c++) begin
      rx_in = (glitch && c == BIT_CLK / 2) ? ~b : b;
      step();
    end
  endtask

  // Sends one frame and updates the reference FIFO/flags by the protocol rules.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_val, input int glitch_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i], glitch_bit == i);
    drive_bit(stop_val, 1'b0);
    if (stop_val) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(data);
      else                      exp_overrun = 1'b1;
    end else begin
      exp_frame = 1'b1;
    end
  endtask

  task automatic read_byte();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check_output({tag, "_count"},    32'(fifo_count), 32'(exp_q.size()));
    check_output({tag, "_valid"},    32'(rx_valid),   32'(exp_q.size() != 0));
    check_output({tag, "_overrun"},  32'(overrun),    32'(exp_overrun));
    check_output({tag, "_frame"},    32'(frame_err),  32'(exp_frame));
    check_output({tag, "_rd_data"},  32'(rd_data),    (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    step();
  endtask

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && rd_en && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_unexpected: got %0h, expected no data", rd_data);
      end else begin
        check_output("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] part;
    logic [7:0] rnd;
    reset       = 1'b1;
    rx_in       = 1'b1;
    rd_en       = 1'b0;
    clr_err     = 1'b0;
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;

    repeat (3) step();
    check_state("reset");
    reset = 1'b0;
    idle(10);

    // Single byte with push-to-valid window around the middle of the stop bit
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(part_bit(8'hA5, i), 1'b0);
    rx_in = 1'b1;
    repeat (32) step();
    @(negedge clk);
    check_output("t1_valid_early", 32'(rx_valid), 32'h0);
    repeat (24) step();
    @(negedge clk);
    check_output("t1_valid_late", 32'(rx_valid), 32'h1);
    check_output("t1_count", 32'(fifo_count), 32'h1);
    check_output("t1_data", 32'(rd_data), 32'hA5);
    exp_q.push_back(8'hA5);
    idle(10);
    read_byte();
    check_state("t1_read");

    // Short low pulse is rejected as a glitch
    rx_in = 1'b0;
    repeat (20) step();
    idle(100);
    check_state("t2_glitch");

    // Back-to-back bytes overflow the FIFO
    for (int b = 1; b <= 5; b++) apply_stimulus(8'(b), 1'b1, -1);
    idle(10);
    check_state("t3_full");
    repeat (4) read_byte();
    check_state("t3_empty");
    read_byte();
    check_state("t3_empty_read");
    pulse_clr();
    check_state("t3_clr");

    // Frame error followed by a long break, then recovery
    apply_stimulus(8'h3C, 1'b0, -1);
    rx_in = 1'b0;
    repeat (300) step();
    check_state("t4_break");
    idle(BIT_CLK * 2);
    check_state("t4_idle");
    apply_stimulus(8'h5A, 1'b1, -1);
    idle(20);
    check_state("t4_next");
    read_byte();
    pulse_clr();
    check_state("t4_clr");

    // One-clock glitch inside a data bit is outvoted
    apply_stimulus(8'h00, 1'b1, 3);
    idle(20);
    check_state("t5_vote");
    read_byte();
    check_state("t5_read");

    // Reset in the middle of a frame with data queued
    apply_stimulus(8'h11, 1'b1, -1);
    apply_stimulus(8'h22, 1'b1, -1);
    idle(10);
    check_state("t6_two");
    part = 8'h96;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i], 1'b0);
    rx_in = part[4];
    repeat (30) step();
    reset = 1'b1;
    exp_q.delete();
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;
    check_state("t6_reset");
    rx_in = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    idle(BIT_CLK);
    apply_stimulus(8'hC3, 1'b1, -1);
    idle(20);
    check_state("t6_after");
    read_byte();
    check_state("t6_read");

    // Randomized traffic with random reads and error clears
    for (int n = 0; n < 16; n++) begin
      rnd = 8'($urandom);
      idle($urandom_range(0, 40));
      apply_stimulus(rnd, 1'b1, -1);
      rx_in = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        read_byte();
        idle($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) pulse_clr();
      check_state("rand");
    end
    while (exp_q.size() != 0) read_byte();
    check_state("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic part_bit(input logic [7:0] value, input int idx);
    return value[idx];
  endfunction

endmodule
